// File: rtl/pwm_multi_out.sv
// pwm_multi_out: multi-channel servo/ESC PWM generator.
// Every frame, channel i drives a pulse of MIN_CYC + target[i]*STEP_CYC cycles,
// aligned to the start of the frame. Targets and arm bits are latched at each
// frame start, and a shutdown request lets the current frame finish first.
// Optional build macro: PWM_DISARM_MIN_EN. When it is defined, disarmed
// channels emit MIN_CYC pulses while busy. When it is undefined, disarmed
// channels stay low.
//
// state | meaning
// IDLE  | outputs low, frame counter held at 0
// RUN   | frames repeat back to back
// DRAIN | current frame finishes, then IDLE (or back to RUN if enable returns)
module pwm_multi_out #(
  parameter int CLK_HZ   = 16000000,
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int FRAME_HZ = 50,
  parameter int MIN_US   = 1000,
  parameter int SPAN_US  = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       arm,
  input  logic [CHANNELS*WIDTH-1:0] targets,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      frame_start,
  output logic                      busy
);

  localparam int CYC_PER_US = CLK_HZ / 1000000;
  localparam int FRAME_CYC  = CLK_HZ / FRAME_HZ;
  localparam int MIN_CYC    = CYC_PER_US * MIN_US;
  localparam int FULL       = (1 << WIDTH) - 1;
  localparam int STEP_CYC   = (CYC_PER_US * SPAN_US) / FULL;
  localparam int CNT_W      = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] STEP    = CNT_W'(STEP_CYC);

  if (CLK_HZ % 1000000 != 0) begin : g_err_clk
    $error("pwm_multi_out: CLK_HZ must be an integer multiple of 1 MHz");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_err_ch
    $error("pwm_multi_out: CHANNELS must be 1..16");
  end
  if (WIDTH < 4 || WIDTH > 12) begin : g_err_w
    $error("pwm_multi_out: WIDTH must be 4..12");
  end
  if (MIN_CYC + FULL * STEP_CYC >= FRAME_CYC) begin : g_err_frame
    $error("pwm_multi_out: longest pulse does not fit inside one frame");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [CHANNELS-1:0]       arm_q, arm_nxt;
  logic [CHANNELS*WIDTH-1:0] tgt_q, tgt_nxt;
  logic [CHANNELS-1:0]       pwm_nxt;
  logic                      new_frame;
  logic [CNT_W-1:0]          pulse [CHANNELS];

  // State, frame counter, latched configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      arm_q       <= '0;
      tgt_q       <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      arm_q       <= arm_nxt;
      tgt_q       <= tgt_nxt;
      pwm_out     <= pwm_nxt;
      frame_start <= new_frame;
      busy        <= (state_nxt != IDLE);
    end
  end

  // Next state/counter. Each output is computed from the values that the
  // counter and latched targets take next, so the outputs line up with cnt.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    new_frame = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          state_nxt = RUN;
          new_frame = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (enable) new_frame = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (!enable) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (enable) begin
            state_nxt = RUN;
            new_frame = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (enable) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    arm_nxt = new_frame ? arm : arm_q;
    tgt_nxt = new_frame ? targets : tgt_q;

    for (int i = 0; i < CHANNELS; i++) begin
      pulse[i] = MIN_CNT + CNT_W'(tgt_nxt[i*WIDTH +: WIDTH]) * STEP;
      if (state_nxt == IDLE) begin
        pwm_nxt[i] = 1'b0;
      end else if (arm_nxt[i]) begin
        pwm_nxt[i] = (cnt_nxt < pulse[i]);
      end else begin
`ifdef PWM_DISARM_MIN_EN
        pwm_nxt[i] = (cnt_nxt < MIN_CNT);
`else
        pwm_nxt[i] = 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_out.sv
// tb_pwm_multi_out: directed bench for pwm_multi_out, using scaled timing.
// Timing: 2 MHz clock, 1000-cycle frames, MIN_CYC = 100, STEP_CYC = floor(600/255) = 2.
// The expected pulse widths follow from these values:
//   target 0 -> 100, 1 -> 102, 64 -> 228, 128 -> 356, 255 -> 610.
module tb_pwm_multi_out;

  localparam int FR   = 1000;
  localparam int MINW = 100;
`ifdef PWM_DISARM_MIN_EN
  localparam int DIS_W = 100;
`else
  localparam int DIS_W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  arm;
  logic [31:0] targets;
  logic [3:0]  pwm_out;
  logic        frame_start;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int fs_last = 0;
  int fs_period = 0;
  int fs_count = 0;
  int hcnt [4] = '{0, 0, 0, 0};
  int frame_w [4] = '{0, 0, 0, 0};

  pwm_multi_out #(
    .CLK_HZ(2000000), .CHANNELS(4), .WIDTH(8),
    .FRAME_HZ(2000), .MIN_US(50), .SPAN_US(300)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .arm(arm), .targets(targets),
    .pwm_out(pwm_out), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: frame_start period and the number of high cycles per channel in each frame
  always @(negedge clk) begin
    if (frame_start) begin
      fs_period = cyc - fs_last;
      fs_last   = cyc;
      fs_count++;
      for (int i = 0; i < 4; i++) begin
        frame_w[i] = hcnt[i];
        hcnt[i]    = pwm_out[i] ? 1 : 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) hcnt[i] += pwm_out[i] ? 1 : 0;
    end
    cyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < FR + 100);
    if (!frame_start) chk("fs_timeout", 0, 1);
  endtask

  task automatic chk_widths(input string tag, input int w0, input int w1,
                            input int w2, input int w3);
    chk({tag, "_ch0"}, frame_w[0], w0);
    chk({tag, "_ch1"}, frame_w[1], w1);
    chk({tag, "_ch2"}, frame_w[2], w2);
    chk({tag, "_ch3"}, frame_w[3], w3);
  endtask

  initial begin
    int c;
    rst_n   = 1'b0;
    enable  = 1'b0;
    arm     = 4'h0;
    targets = 32'h0;
    ticks(3);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    ticks(2);
    chk("idle_busy", int'(busy), 0);

    // Start-up: frame_start one cycle after enable is sampled; all channels rise together
    arm     = 4'hF;
    targets = {8'd1, 8'd255, 8'd128, 8'd0};
    enable  = 1'b1;
    tick();
    chk("start_fs", int'(frame_start), 1);
    chk("start_pwm", int'(pwm_out), 4'hF);
    chk("start_busy", int'(busy), 1);
    tick();
    chk("fs_one_cycle", int'(frame_start), 0);
    wait_fs();
    chk("period_a", fs_period, FR);
    chk_widths("frame_a", 100, 356, 610, 102);

    // Changes made mid-frame take effect only at the next frame start
    ticks(50);
    targets = {8'd1, 8'd255, 8'd255, 8'd255};
    arm     = 4'b0111;
    wait_fs();
    chk_widths("frame_b", 100, 356, 610, 102);
    wait_fs();
    chk("period_c", fs_period, FR);
    chk_widths("frame_c", 610, 610, 610, DIS_W);

    // Drain: enable drops mid-pulse, and the frame still completes untouched
    ticks(200);
    enable = 1'b0;
    ticks(409);
    chk("drain_pwm_609", int'(pwm_out), 4'b0111);
    tick();
    chk("drain_pwm_610", int'(pwm_out), 0);
    ticks(389);
    chk("drain_busy_999", int'(busy), 1);
    tick();
    chk("drain_busy_1000", int'(busy), 0);
    chk("drain_no_fs", int'(frame_start), 0);
    c = fs_count;
    ticks(1500);
    chk("idle_no_fs", fs_count, c);
    chk("idle_pwm", int'(pwm_out), 0);

    // Restart from IDLE; then drop enable and raise it again inside one frame
    enable = 1'b1;
    tick();
    chk("restart_fs", int'(frame_start), 1);
    ticks(200);
    enable = 1'b0;
    ticks(200);
    enable = 1'b1;
    chk("reraise_busy", int'(busy), 1);
    wait_fs();
    chk("reraise_period", fs_period, FR);

    // Partial arm mask with equal targets
    ticks(10);
    arm     = 4'b0101;
    targets = {8'd64, 8'd64, 8'd64, 8'd64};
    wait_fs();
    wait_fs();
    chk_widths("frame_arm", 228, DIS_W, 228, DIS_W);

    // Asynchronous reset in the middle of a pulse
    ticks(50);
    chk("pre_rst_pwm", int'(pwm_out & 4'b0101), 4'b0101);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_fs", int'(frame_start), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_fs", int'(frame_start), 1);
    chk("post_rst_pwm", int'(pwm_out), 4'b0101);
    wait_fs();
    chk("post_rst_period", fs_period, FR);
    chk("post_rst_ch0", frame_w[0], 228);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_multi_out.md
# pwm_multi_out

Parametrised multi-channel servo/ESC PWM generator; successor to the single-channel 8-bit PWM output stage. Produces CHANNELS frame-aligned pulses of MIN_US + target·step width once per frame, with per-channel arming, frame-boundary target latching and glitch-free shutdown. Sits between the command decoder (target bus) and the ESC output pins.

## Interface
- CLK_HZ, 16000000, system clock frequency; must be an integer multiple of 1 MHz.
- CHANNELS, 4, number of PWM outputs (1..16).
- WIDTH, 8, target resolution in bits (4..12).
- FRAME_HZ, 50, frame rate.
- MIN_US, 1000, pulse width for target 0.
- SPAN_US, 1000, nominal added width at full-scale target.
- Derived: FRAME_CYC = CLK_HZ/FRAME_HZ; MIN_CYC = (CLK_HZ/1000000)·MIN_US; STEP_CYC = floor((CLK_HZ/1000000)·SPAN_US / (2^WIDTH−1)); MIN_CYC + (2^WIDTH−1)·STEP_CYC < FRAME_CYC is required (elaboration error otherwise).

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global run request.
- arm  in  CHANNELS  per-channel arm mask.
- targets  in  CHANNELS·WIDTH  channel i target at bits [i·WIDTH +: WIDTH].
- pwm_out  out  CHANNELS  pulse outputs.
- frame_start  out  1  one-cycle strobe at each frame start.
- busy  out  1  high in RUN or DRAIN.

## Operation
- States: IDLE, RUN, DRAIN. Reset: IDLE, frame counter 0, latched targets/arm 0, pwm_out=0, frame_start=0, busy=0.
- IDLE: outputs low, counter held 0. enable sampled 1 → RUN, new frame starts.
- Frame start (IDLE→RUN, or counter wrap at FRAME_CYC−1 while RUN): latch targets and arm; compute pulse_cyc[i] = MIN_CYC + target[i]·STEP_CYC (full precision, no truncation); assert frame_start.
- Mid-frame changes to targets/arm are ignored until next frame start.
- Channel i high for pulse_cyc[i] cycles if latched arm[i]=1; disarmed channels per Configuration.
- RUN, enable sampled 0 → DRAIN: current frame completes unchanged (no truncated pulse).
- DRAIN: enable sampled 1 again → RUN, no restart, frame counter continues. Reaching FRAME_CYC−1 with enable=0 → IDLE; no new frame_start.
- Reset asserted mid-pulse: all outputs low immediately (asynchronous); IDLE.

## Timing
- frame_start and rising pwm_out occur the cycle after the edge that samples enable=1 in IDLE (1-cycle latency); all outputs registered.
- pwm_out[i] rises in the frame_start cycle and stays high exactly pulse_cyc[i] consecutive cycles.
- frame_start period exactly FRAME_CYC cycles while in RUN; all channels rise on the same cycle.
- busy high from the frame_start cycle of the first frame through the last cycle of the final drained frame.
- target equal on all channels ⇒ identical, cycle-aligned edges.

## Configuration
- PWM_DISARM_MIN_EN defined: latched-disarmed channels emit MIN_CYC pulses every frame while busy (ESC idle/arm signal); IDLE remains all low.
- Undefined: latched-disarmed channels stay low for the whole frame.

## Test plan
- Defaults, arm=4'hF, targets 0/128/255/1: enable=1 → pulses of 16000/23936/31810/16062 cycles, frame_start every 320000 cycles.
- targets changed from 0 to 255 at cycle 100 of frame: current pulse stays 16000; next frame 31810.
- enable dropped at cycle 20000 of a frame with target 255: pulse completes at 31810, busy falls at frame end (cycle 319999), no further frame_start; re-raise during DRAIN → next frame_start exactly 320000 after previous.
- arm=4'b0101, targets all 64: ch0/ch2 pulse 19968 cycles; ch1/ch3 low (macro off) or 16000 cycles (macro on).
- rst_n pulled low at cycle 5000 of a pulse: pwm_out=0 same cycle, busy=0; after release with enable=1, first frame_start 1 cycle after first sampling edge.
- CHANNELS=1, WIDTH=12: target 4095 → 16000 + 4095·3 = 28285-cycle pulse.
